// File: rtl/uart_apb_cmd_bridge.sv
// Purpose : ASCII-hex UART command parser driving an APB3 master (single read, single write, burst read).
// Latency : last command char popped at N -> SETUP N+1, ACCESS N+2, first response char pushed N+3.
// Backpr. : pops RX only while parsing; pushes TX only when tx_full=0 and advances char index on push.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   rx_data/rx_empty/rx_pop RX FIFO head, empty flag, pop strobe (combinational)
//   tx_data/tx_push/tx_full TX FIFO byte, push strobe (combinational), full flag
//   paddr/pwrite/penable/pwdata/prdata/pready/pslverr  APB3 master side (psel decoded outside)
//   busy                    high whenever the FSM is not IDLE
module uart_apb_cmd_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_pop,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    input  logic              tx_full,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
);

    localparam int AN    = ADDR_W / 4;
    localparam int DN    = DATA_W / 4;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
    localparam logic [3:0]        AN_LAST = 4'(AN - 1);
    localparam logic [3:0]        DN_LAST = 4'(DN - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DATA, CNT, SETUP, ACCESS, TXDATA, TXSUM, TXSTAT, TXERR
    } state_t;

    state_t            state;
    logic              is_s;       // first command char was 'S'
    logic              is_write;
    logic              is_burst;
    logic [3:0]        idx;        // char index within the current field
    logic [7:0]        cnt_q;      // burst words still to run after the current one
    logic [TO_W-1:0]   tcnt;
    logic [DATA_W-1:0] rdata_q;    // shifted left one nibble per pushed char
    logic [7:0]        sum_q;
    logic [7:0]        stat_q;
    logic [4:0]        dec;        // {valid, nibble} of rx_data
    logic              parse_st;
    logic              tx_st;

    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
        else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // Checksum over the received fields; paddr/pwdata still hold them for a write.
    function automatic logic [7:0] calc_sum(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < ADDR_W / 8; i++) s = s + a[8*i +: 8];
        for (int i = 0; i < DATA_W / 8; i++) s = s + d[8*i +: 8];
        return s;
    endfunction

    always_comb begin
        dec      = hex_dec(rx_data);
        parse_st = (state == IDLE) || (state == CMD) || (state == ADDR) ||
                   (state == DATA) || (state == CNT);
        tx_st    = (state == TXDATA) || (state == TXSUM) || (state == TXSTAT) ||
                   (state == TXERR);
        rx_pop   = reset_n & ~rx_empty & parse_st;
        tx_push  = reset_n & ~tx_full & tx_st;
        tx_data  = 8'h00;
        case (state)
            TXDATA:  tx_data = hex_enc(rdata_q[DATA_W-1 -: 4]);
            TXSUM:   tx_data = hex_enc(sum_q[7:4]);
            TXSTAT:  tx_data = stat_q;
            TXERR:   tx_data = 8'h3F;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            is_s     <= 1'b0;
            is_write <= 1'b0;
            is_burst <= 1'b0;
            idx      <= '0;
            cnt_q    <= '0;
            tcnt     <= '0;
            rdata_q  <= '0;
            sum_q    <= '0;
            stat_q   <= 8'h4B;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        if (rx_data == 8'h53) begin          // 'S'
                            is_s  <= 1'b1;
                            busy  <= 1'b1;
                            state <= CMD;
                        end else if (rx_data == 8'h42) begin // 'B'
                            is_s  <= 1'b0;
                            busy  <= 1'b1;
                            state <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (!rx_empty) begin
                        idx   <= '0;
                        cnt_q <= '0;
                        if (is_s && rx_data == 8'h52) begin          // SR
                            is_write <= 1'b0;
                            is_burst <= 1'b0;
                            state    <= ADDR;
                        end else if (is_s && rx_data == 8'h57) begin // SW
                            is_write <= 1'b1;
                            is_burst <= 1'b0;
                            state    <= ADDR;
                        end else if (!is_s && rx_data == 8'h52) begin // BR
                            is_write <= 1'b0;
                            is_burst <= 1'b1;
                            state    <= ADDR;
                        end else begin
                            state <= TXERR;
                        end
                    end
                end
                ADDR: begin
                    if (!rx_empty) begin
                        if (!dec[4]) begin
                            state <= TXERR;
                        end else begin
                            paddr <= {paddr[ADDR_W-5:0], dec[3:0]};
                            if (idx == AN_LAST) begin
                                idx <= '0;
                                if (is_write)      state <= DATA;
                                else if (is_burst) state <= CNT;
                                else               state <= SETUP;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (!rx_empty) begin
                        if (!dec[4]) begin
                            state <= TXERR;
                        end else begin
                            pwdata <= {pwdata[DATA_W-5:0], dec[3:0]};
                            if (idx == DN_LAST) begin
                                idx    <= '0;
                                pwrite <= 1'b1;
                                state  <= SETUP;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                CNT: begin
                    if (!rx_empty) begin
                        if (!dec[4]) begin
                            state <= TXERR;
                        end else begin
                            cnt_q <= {cnt_q[3:0], dec[3:0]};
                            if (idx == 4'd1) begin
                                idx   <= '0;
                                state <= SETUP;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        idx     <= '0;
                        if (is_write) begin
                            sum_q  <= calc_sum(paddr, pwdata);
                            stat_q <= pslverr ? 8'h45 : 8'h4B;
                            state  <= TXSUM;
                        end else if (pslverr) begin
                            // failed word: data chars suppressed, burst abandoned
                            stat_q <= 8'h45;
                            state  <= TXSTAT;
                        end else begin
                            rdata_q <= prdata;
                            stat_q  <= 8'h4B;
                            state   <= TXDATA;
                            if (is_burst) paddr <= paddr + STEP;
                        end
                    end else if (TO_EN && tcnt == TO_LAST) begin
                        // this is the TIMEOUT-th ACCESS cycle without pready
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        idx     <= '0;
                        stat_q  <= 8'h54;
                        if (is_write) begin
                            sum_q <= calc_sum(paddr, pwdata);
                            state <= TXSUM;
                        end else begin
                            state <= TXSTAT;
                        end
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                TXDATA: begin
                    if (!tx_full) begin
                        rdata_q <= rdata_q << 4;
                        if (idx == DN_LAST) begin
                            idx <= '0;
                            if (cnt_q != 8'd0) begin
                                cnt_q <= cnt_q - 8'd1;
                                state <= SETUP;
                            end else begin
                                state <= TXSTAT;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                TXSUM: begin
                    if (!tx_full) begin
                        sum_q <= sum_q << 4;
                        if (idx == 4'd1) begin
                            idx   <= '0;
                            state <= TXSTAT;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                TXSTAT, TXERR: begin
                    if (!tx_full) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_cmd_bridge.sv
module tb_uart_apb_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full;
    logic [31:0] paddr;
    logic        pwrite;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;

    uart_apb_cmd_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
        .paddr(paddr), .pwrite(pwrite), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]   rxq[$];
    logic         pop_pend = 1'b0;
    logic [255:0] txv;
    int           txn;
    int           cyc = 0;
    int           last_pop_cyc;
    int           first_push_cyc;
    int           xfers;
    int           pen_cyc;
    logic [31:0]  xa0, xa1, xwd;
    logic         xwr;
    logic         push_busy;
    int           stall_at = -1;
    int           stall_cnt = 0;
    logic         ready_off = 1'b0;
    int           err_at = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hDEADBEEF;
            32'hFFFF_FFFC: return 32'h01234567;
            32'h0000_0000: return 32'h89ABCDEF;
            32'h0000_0004: return 32'h55AA55AA;
            default:       return 32'h0BADF00D;
        endcase
    endfunction

    // FIFO / APB slave models: inputs change on negedge, outputs sampled 1 ns later.
    initial begin
        rx_empty = 1'b1; rx_data = 8'h00; tx_full = 1'b0;
        pready = 1'b1; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pend && rxq.size() > 0) rxq.delete(0);
            rx_empty = (rxq.size() == 0);
            rx_data  = rx_empty ? 8'h00 : rxq[0];
            tx_full  = (stall_cnt > 0);
            if (stall_cnt > 0) stall_cnt--;
            pready   = !ready_off;
            prdata   = rd_val(paddr);
            pslverr  = (err_at != 0) && (xfers + 1 == err_at);
            #1;
            pop_pend = rx_pop;
            if (rx_pop) last_pop_cyc = cyc;
            if (penable) pen_cyc++;
            if (penable && pready) begin
                if (xfers == 0) xa0 = paddr;
                if (xfers == 1) xa1 = paddr;
                xwr = pwrite;
                xwd = pwdata;
                xfers++;
            end
            if (tx_push) begin
                if (txn == 0) first_push_cyc = cyc;
                push_busy = busy;
                txv = {txv[247:0], tx_data};
                txn++;
                if (txn == stall_at) begin
                    stall_cnt = 5;
                    stall_at  = -1;
                end
            end
        end
    end

    task automatic clear_log();
        txv = '0; txn = 0; xfers = 0; pen_cyc = 0;
        first_push_cyc = -1; xa0 = '0; xa1 = '0; xwd = '0; xwr = 1'b0;
    endtask

    task automatic run_cmd(input string s);
        int idle_cnt;
        clear_log();
        for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
        idle_cnt = 0;
        for (int c = 0; c < 600 && idle_cnt < 3; c++) begin
            @(negedge clk); #2;
            if (rxq.size() == 0 && !busy) idle_cnt++;
            else idle_cnt = 0;
        end
        chk({"done_", s}, idle_cnt, 3);
    endtask

    initial begin
        reset_n = 1'b0;
        rxq.push_back(8'h58);     // 'X' waiting during reset, later ignored in IDLE
        repeat (3) @(negedge clk);
        #2;
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_penable", penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_pop", rx_pop, 0);
        chk("rst_tx_push", tx_push, 0);
        reset_n = 1'b1;

        // single read
        run_cmd("SR00001000");
        chk("sr_tx", txv, "DEADBEEFK");
        chk("sr_lat", first_push_cyc - last_pop_cyc, 3);
        chk("sr_addr", xa0, 32'h0000_1000);
        chk("sr_pwrite", xwr, 0);
        chk("sr_xfers", xfers, 1);
        chk("sr_pen", pen_cyc, 1);

        // single write
        run_cmd("SW0000001012345678");
        chk("sw_tx", txv, "24K");
        chk("sw_addr", xa0, 32'h10);
        chk("sw_wdata", xwd, 32'h12345678);
        chk("sw_pwrite", xwr, 1);
        chk("sw_pwrite_idle", pwrite, 0);

        // burst with address wrap and TX backpressure mid-word
        stall_at = 4;
        run_cmd("BRFFFFFFFC01");
        chk("br_tx", txv, "0123456789ABCDEFK");
        chk("br_n", txn, 17);
        chk("br_a0", xa0, 32'hFFFF_FFFC);
        chk("br_a1", xa1, 32'h0000_0000);
        chk("br_xfers", xfers, 2);

        // read slave error
        err_at = 1;
        run_cmd("SR00000004");
        chk("se_tx", txv, "E");
        chk("se_xfers", xfers, 1);

        // burst error on the second word
        err_at = 2;
        run_cmd("BR0000000003");
        chk("be_tx", txv, "89ABCDEFE");
        chk("be_xfers", xfers, 2);
        err_at = 0;

        // timeout
        ready_off = 1'b1;
        run_cmd("SR00000000");
        chk("to_tx", txv, "T");
        chk("to_pen", pen_cyc, 8);
        chk("to_busy_at_push", push_busy, 1);
        chk("to_busy_end", busy, 0);
        chk("to_penable_end", penable, 0);
        ready_off = 1'b0;

        // syntax errors then a good read
        run_cmd("SR00GXSQSR00000000");
        chk("syn_tx", txv, "??89ABCDEFK");
        chk("syn_xfers", xfers, 1);

        // reset during ACCESS
        clear_log();
        ready_off = 1'b1;
        begin
            string s;
            logic  seen;
            s = "SR00000000";
            for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
            seen = 1'b0;
            for (int c = 0; c < 60 && !seen; c++) begin
                @(negedge clk); #2;
                seen = penable;
            end
            chk("rr_pen_seen", seen, 1);
        end
        reset_n = 1'b0;
        @(negedge clk); #2;
        chk("rr_penable", penable, 0);
        chk("rr_busy", busy, 0);
        chk("rr_tx_push", tx_push, 0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        chk("rr_txn", txn, 0);
        chk("rr_busy_after", busy, 0);
        ready_off = 1'b0;
        run_cmd("SR00001000");
        chk("rr_recover_tx", txv, "DEADBEEFK");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
